// File: rtl/spio_irq.sv
// spio_irq: board LED/button/switch controller on a Wishbone pipelined bus.
// Four word registers: CTRL (LED value, brightness, demo), INPUT (debounced
// buttons, synchronised switches), PEND (write-1-to-clear event latches),
// IEN (interrupt enables). o_int is the registered OR of PEND & IEN.
//
// Optional feature: define SPIO_PWM_EN to add global 8-bit PWM dimming of
// the LED outputs via CTRL[23:16]. Without it the brightness field reads 0.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_wb_cyc/stb/we/addr/data/sel  Wishbone request
//   o_wb_stall/ack/data       Wishbone response (stall tied low)
//   i_sw [NSW]                asynchronous switches
//   i_btn [NBTN]              asynchronous active-high buttons
//   o_led [NLEDS]             LED drive
//   o_int                     level interrupt, active-high
module spio_irq #(
  parameter int NLEDS       = 8,
  parameter int NBTN        = 5,
  parameter int NSW         = 4,
  parameter int DEBOUNCE_LG = 16,
  parameter int DEMO_LG     = 22
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  input  logic [NSW-1:0]   i_sw,
  input  logic [NBTN-1:0]  i_btn,
  output logic [NLEDS-1:0] o_led,
  output logic             o_int
);

  localparam int PW = (NLEDS > 1) ? $clog2(NLEDS) : 1;

  // Bits of PEND/IEN that correspond to real buttons and switches.
  function automatic logic [31:0] f_pin_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 16; i++) begin
      m[i]      = (i < NBTN);
      m[16 + i] = (i < NSW);
    end
    return m;
  endfunction

  // Expand byte selects into a 32-bit write mask.
  function automatic logic [31:0] f_byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  localparam logic [31:0] PIN_MASK = f_pin_mask();

  // Registers
  logic                   r_ack;
  logic [31:0]            r_rdata;
  logic [NLEDS-1:0]       r_led_val;
  logic                   r_demo;
  logic [NSW-1:0]         r_sw_s1, r_sw_s2, r_sw_hist;
  logic [1:0]             r_sw_arm;
  logic [NBTN-1:0]        r_btn_s1, r_btn_s2, r_btn_samp, r_btn_deb;
  logic [DEBOUNCE_LG-1:0] r_dbc_cnt;
  logic [31:0]            r_pend, r_ien;
  logic                   r_int;
  logic [DEMO_LG-1:0]     r_demo_cnt;
  logic [PW-1:0]          r_pos;
  logic                   r_dir_dn;
  logic [NLEDS-1:0]       r_led;
`ifdef SPIO_PWM_EN
  logic [7:0]             r_bright;
  logic [7:0]             r_pwm_cnt;
`endif

  // Wires
  logic                   w_wr;
  logic [31:0]            w_bmask;
  logic                   w_wr_ctrl, w_wr_pend, w_wr_ien;
  logic [15:0]            w_led_ext;
  logic [7:0]             w_bright_rd;
  logic                   w_tick, w_demo_tick, w_gate;
  logic [NBTN-1:0]        w_agree, w_btn_deb_nxt, w_btn_press;
  logic [31:0]            w_set, w_pend_clr, w_rd;
  logic [NLEDS-1:0]       w_sweep, w_led_sel;

  assign w_wr        = i_wb_cyc & i_wb_stb & i_wb_we;
  assign w_bmask     = f_byte_mask(i_wb_sel);
  assign w_wr_ctrl   = w_wr & (i_wb_addr == 2'd0);
  assign w_wr_pend   = w_wr & (i_wb_addr == 2'd2);
  assign w_wr_ien    = w_wr & (i_wb_addr == 2'd3);
  assign w_led_ext   = 16'(r_led_val);
  assign w_tick      = (r_dbc_cnt == {DEBOUNCE_LG{1'b1}});
  assign w_demo_tick = (r_demo_cnt == {DEMO_LG{1'b1}});
  // A debounced bit only follows the sample when two consecutive ticks agree.
  assign w_agree       = ~(r_btn_s2 ^ r_btn_samp);
  assign w_btn_deb_nxt = w_tick ? ((r_btn_deb & ~w_agree) | (r_btn_s2 & w_agree)) : r_btn_deb;
  assign w_btn_press   = w_btn_deb_nxt & ~r_btn_deb;
  assign w_pend_clr    = w_wr_pend ? (i_wb_data & w_bmask) : 32'd0;
  assign w_led_sel     = r_demo ? w_sweep : r_led_val;

`ifdef SPIO_PWM_EN
  assign w_bright_rd = r_bright;
  assign w_gate      = (r_bright == 8'hFF) | (r_pwm_cnt < r_bright);
`else
  assign w_bright_rd = 8'd0;
  assign w_gate      = 1'b1;
`endif

  // Event vector in PEND layout; switch events held off while the sync chain fills.
  always_comb begin
    w_set = 32'd0;
    w_set[NBTN-1:0] = w_btn_press;
    if (r_sw_arm == 2'd3) begin
      w_set[16 +: NSW] = r_sw_s2 ^ r_sw_hist;
    end else begin
      w_set[16 +: NSW] = {NSW{1'b0}};
    end
  end

  // Register read mux.
  always_comb begin
    w_rd = 32'd0;
    case (i_wb_addr)
      2'd0:    w_rd = {r_demo, 7'd0, w_bright_rd, w_led_ext};
      2'd1:    w_rd = {16'(r_sw_s2), 16'(r_btn_deb)};
      2'd2:    w_rd = r_pend;
      2'd3:    w_rd = r_ien;
      default: w_rd = 32'd0;
    endcase
  end

  // One-hot decode of the demo sweep position.
  always_comb begin
    w_sweep = {NLEDS{1'b0}};
    for (int i = 0; i < NLEDS; i++) begin
      w_sweep[i] = (r_pos == PW'(i));
    end
  end

  // Bus response: every strobe acks next cycle with the pre-write register value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack <= i_wb_stb;
      if (i_wb_stb) begin
        r_rdata <= w_rd;
      end
    end
  end

  // CTRL register with per-byte writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led_val <= {NLEDS{1'b0}};
      r_demo    <= 1'b1;
    end else if (w_wr_ctrl) begin
      r_led_val <= (r_led_val & ~w_bmask[NLEDS-1:0]) | (i_wb_data[NLEDS-1:0] & w_bmask[NLEDS-1:0]);
      if (i_wb_sel[3]) begin
        r_demo <= i_wb_data[31];
      end
    end
  end

`ifdef SPIO_PWM_EN
  // Brightness register and free-running PWM counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bright  <= 8'hFF;
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (w_wr_ctrl && i_wb_sel[2]) begin
        r_bright <= i_wb_data[23:16];
      end
    end
  end
`endif

  // Input synchronisers, switch history, and button debouncer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sw_s1    <= {NSW{1'b0}};
      r_sw_s2    <= {NSW{1'b0}};
      r_sw_hist  <= {NSW{1'b0}};
      r_sw_arm   <= 2'd0;
      r_btn_s1   <= {NBTN{1'b0}};
      r_btn_s2   <= {NBTN{1'b0}};
      r_btn_samp <= {NBTN{1'b0}};
      r_btn_deb  <= {NBTN{1'b0}};
      r_dbc_cnt  <= {DEBOUNCE_LG{1'b0}};
    end else begin
      r_sw_s1   <= i_sw;
      r_sw_s2   <= r_sw_s1;
      r_sw_hist <= r_sw_s2;
      if (r_sw_arm != 2'd3) begin
        r_sw_arm <= r_sw_arm + 2'd1;
      end
      r_btn_s1  <= i_btn;
      r_btn_s2  <= r_btn_s1;
      r_dbc_cnt <= r_dbc_cnt + DEBOUNCE_LG'(1);
      if (w_tick) begin
        r_btn_samp <= r_btn_s2;
      end
      r_btn_deb <= w_btn_deb_nxt;
    end
  end

  // Pending/enable registers and interrupt; a same-cycle event beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend <= 32'd0;
      r_ien  <= 32'd0;
      r_int  <= 1'b0;
    end else begin
      r_pend <= ((r_pend & ~w_pend_clr) | w_set) & PIN_MASK;
      if (w_wr_ien) begin
        r_ien <= ((r_ien & ~w_bmask) | (i_wb_data & w_bmask)) & PIN_MASK;
      end
      r_int <= |(r_pend & r_ien);
    end
  end

  // Demo sweep: bounce between LED 0 and LED NLEDS-1, one step per prescaler wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_demo_cnt <= {DEMO_LG{1'b0}};
      r_pos      <= {PW{1'b0}};
      r_dir_dn   <= 1'b0;
    end else begin
      r_demo_cnt <= r_demo_cnt + DEMO_LG'(1);
      if (w_demo_tick) begin
        if (NLEDS == 1) begin
          r_pos    <= {PW{1'b0}};
          r_dir_dn <= 1'b0;
        end else if (!r_dir_dn) begin
          if (r_pos == PW'(NLEDS - 1)) begin
            r_dir_dn <= 1'b1;
            r_pos    <= r_pos - PW'(1);
          end else begin
            r_pos <= r_pos + PW'(1);
          end
        end else begin
          if (r_pos == PW'(0)) begin
            r_dir_dn <= 1'b0;
            r_pos    <= r_pos + PW'(1);
          end else begin
            r_pos <= r_pos - PW'(1);
          end
        end
      end
    end
  end

  // Registered LED drive.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_led <= {NLEDS{1'b0}};
    end else begin
      r_led <= w_led_sel & {NLEDS{w_gate}};
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_rdata;
  assign o_led      = r_led;
  assign o_int      = r_int;

endmodule
